// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned      FETCH_XLEN     = 32;
  localparam logic [31:0]      FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC candidates for the fetch stage: sequential pc+4 and word-aligned
// redirect target, plus detection of a non-word-aligned target.
module fetch_pc_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] target_aligned_o,
  output logic            misaligned_o
);

  // pc+4 wraps naturally at 2^XLEN; low target bits are cleared but reported
  always_comb begin
    pc_plus4_o       = pc_i + XLEN'(3'd4);
    target_aligned_o = {target_i[XLEN-1:2], 2'b00};
    misaligned_o     = |target_i[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from instruction
// memory (req/ack) and hands them to decode (valid/ready). Redirects from
// execute squash whatever is in flight or held.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BOOT  | just out of reset, no request yet
// ST_REQ   | request outstanding for addr_q; a returned word is kept
// ST_DRAIN | request outstanding but redirected; returned word is dropped
// ST_HOLD  | instruction presented to decode, waiting for i_Ready
import fetch_unit_pkg::*;

module fetch_unit #(
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_DoBranch,
  input  logic            i_Jump,
  input  logic [XLEN-1:0] i_Target,
  output logic            o_IM_req,
  output logic [XLEN-1:0] o_IM_addr,
  input  logic            i_IM_ack,
  input  logic [XLEN-1:0] i_IM_data,
  output logic            o_Valid,
  input  logic            i_Ready,
  output logic [XLEN-1:0] o_Instr,
  output logic [XLEN-1:0] o_PC,
  output logic            o_Misaligned
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            mis_q, mis_d;

  logic            redirect;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] tgt;
  logic            tgt_mis;

  assign redirect = i_DoBranch | i_Jump;

  fetch_pc_gen #(.XLEN(XLEN)) u_pc_gen (
    .pc_i             (pc_q),
    .target_i         (i_Target),
    .pc_plus4_o       (pc_plus4),
    .target_aligned_o (tgt),
    .misaligned_o     (tgt_mis)
  );

  // Next-state and datapath updates; the request is never withdrawn before ack
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_BOOT: begin
        if (redirect) pc_d = tgt;
        addr_d  = pc_d;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (i_IM_ack) begin
          if (redirect) begin
            pc_d   = tgt;
            addr_d = tgt;
          end else begin
            instr_d = i_IM_data;
            opc_d   = addr_q;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          pc_d    = tgt;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (redirect) pc_d = tgt;
        if (i_IM_ack) begin
          addr_d  = pc_d;
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = tgt;
          addr_d  = tgt;
          state_d = ST_REQ;
        end else if (i_Ready) begin
          valid_d = 1'b0;
          pc_d    = pc_plus4;
          addr_d  = pc_plus4;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // Request output is registered from the state we are entering
    req_d = (state_d == ST_REQ) || (state_d == ST_DRAIN);
    mis_d = redirect & tgt_mis;
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      opc_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      mis_q   <= mis_d;
    end
  end

  assign o_IM_req     = req_q;
  assign o_IM_addr    = addr_q;
  assign o_Valid      = valid_q;
  assign o_Instr      = instr_q;
  assign o_PC         = opc_q;
  assign o_Misaligned = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-computed expectations after each edge.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        do_branch;
  logic        jump;
  logic [31:0] target;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_data;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        mis;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_DoBranch   (do_branch),
    .i_Jump       (jump),
    .i_Target     (target),
    .o_IM_req     (im_req),
    .o_IM_addr    (im_addr),
    .i_IM_ack     (im_ack),
    .i_IM_data    (im_data),
    .o_Valid      (valid),
    .i_Ready      (ready),
    .o_Instr      (instr),
    .o_PC         (pc),
    .o_Misaligned (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock, sample 1 time unit after the edge, check invariant
  task automatic step();
    @(posedge clk);
    #1;
    chk("valid_and_req_exclusive", 32'(valid & im_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1; do_branch = 1'b0; jump = 1'b0; target = '0;
    im_ack = 1'b0; im_data = '0; ready = 1'b0;
    step(); step();
    chk("rst_req",   32'(im_req), 32'd0);
    chk("rst_addr",  im_addr,     32'h0);
    chk("rst_valid", 32'(valid),  32'd0);
    chk("rst_instr", instr,       32'h0);
    chk("rst_pc",    pc,          32'h0);
    chk("rst_mis",   32'(mis),    32'd0);

    // sequential fetch, zero-wait memory
    rst = 1'b0;
    step();
    chk("boot_req",  32'(im_req), 32'd1);
    chk("boot_addr", im_addr,     32'h0);
    im_ack = 1'b1; im_data = 32'h0000_0013; ready = 1'b1;
    step();
    chk("seq0_valid", 32'(valid), 32'd1);
    chk("seq0_pc",    pc,         32'h0);
    chk("seq0_instr", instr,      32'h0000_0013);
    step();
    chk("seq1_addr",  im_addr,    32'h4);
    chk("seq1_vlow",  32'(valid), 32'd0);
    step();
    chk("seq1_pc",    pc,         32'h4);
    step();
    chk("seq2_addr",  im_addr,    32'h8);
    step();
    chk("seq2_pc",    pc,         32'h8);
    chk("seq2_instr", instr,      32'h0000_0013);

    // stall decode in HOLD
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(valid),  32'd1);
      chk("stall_pc",    pc,          32'h8);
      chk("stall_instr", instr,       32'h0000_0013);
      chk("stall_req",   32'(im_req), 32'd0);
    end
    ready = 1'b1;
    step();
    chk("release_addr", im_addr,     32'hC);
    chk("release_req",  32'(im_req), 32'd1);

    // redirect during REQ with delayed ack
    im_ack = 1'b0; ready = 1'b0; do_branch = 1'b1; target = 32'h100;
    step();
    chk("drain_addr", im_addr,     32'hC);
    chk("drain_req",  32'(im_req), 32'd1);
    do_branch = 1'b0;
    step();
    chk("drain_addr2", im_addr, 32'hC);
    step();
    chk("drain_addr3", im_addr, 32'hC);
    im_ack = 1'b1; im_data = 32'hDEAD_BEEF;
    step();
    chk("drain_done_addr",  im_addr,    32'h100);
    chk("drain_done_valid", 32'(valid), 32'd0);
    im_data = 32'h0000_0093;
    step();
    chk("tgt_valid", 32'(valid), 32'd1);
    chk("tgt_pc",    pc,         32'h100);
    chk("tgt_instr", instr,      32'h0000_0093);

    // redirect beats ready in HOLD
    ready = 1'b1; do_branch = 1'b1; target = 32'h200; im_ack = 1'b0;
    step();
    chk("hold_redir_addr",  im_addr,    32'h200);
    chk("hold_redir_valid", 32'(valid), 32'd0);
    chk("hold_redir_mis",   32'(mis),   32'd0);
    do_branch = 1'b0;

    // misaligned jump, ack in same cycle: data dropped, aligned target refetched
    jump = 1'b1; target = 32'h302; im_ack = 1'b1; im_data = 32'h1111_1111;
    step();
    chk("mis_pulse", 32'(mis),    32'd1);
    chk("mis_addr",  im_addr,     32'h300);
    chk("mis_req",   32'(im_req), 32'd1);
    chk("mis_valid", 32'(valid),  32'd0);
    jump = 1'b0; im_data = 32'h0000_0013;
    step();
    chk("mis_clear", 32'(mis), 32'd0);
    chk("mis_pc",    pc,       32'h300);
    im_ack = 1'b0;
    step();
    chk("wrap_seq_addr", im_addr, 32'h304);

    // reset while draining
    do_branch = 1'b1; target = 32'h400;
    step();
    chk("pre_rst_addr", im_addr, 32'h304);
    do_branch = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_req",   32'(im_req), 32'd0);
    chk("async_addr",  im_addr,     32'h0);
    chk("async_valid", 32'(valid),  32'd0);
    chk("async_pc",    pc,          32'h0);
    chk("async_instr", instr,       32'h0);
    im_ack = 1'b1; im_data = 32'hBAD0_BAD0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_addr",  im_addr,    32'h0);
    chk("post_rst_valid", 32'(valid), 32'd0);
    im_ack = 1'b0;
    step();
    chk("post_rst_wait", 32'(valid), 32'd0);
    im_ack = 1'b1; im_data = 32'h0000_0013;
    step();
    chk("post_rst_pc",    pc,    32'h0);
    chk("post_rst_instr", instr, 32'h0000_0013);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
